// File: rtl/tri_raster_pkg.sv
// Shared types for the fp-3D triangle rasterizer: coordinate, vector and edge widths plus FSM states.
package fp3d_pkg;
  localparam int COORD_W = 6;
  localparam int EDGE_W  = 2 * COORD_W + 6;

  typedef logic [COORD_W-1:0]        coord_t;
  typedef logic signed [COORD_W:0]   vec_t;
  typedef logic signed [EDGE_W-1:0]  edge_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SCAN  = 2'd2,
    DRAIN = 2'd3
  } raster_state_t;
endpackage

// File: rtl/tri_raster_if.sv
// Triangle-in / pixel-out bus of tri_raster; master drives triangles and pixel ready.
interface tri_raster_if
  import fp3d_pkg::*;
#(
  parameter int W = COORD_W
);
  logic [W-1:0]      point_ax, point_ay;
  logic signed [W:0] vec_ab_x, vec_ab_y, vec_ac_x, vec_ac_y;
  logic              tri_valid_in, tri_ready_out;
  logic [W-1:0]      pix_x_out, pix_y_out;
  logic              pix_valid_out, pix_ready_in;
  logic              busy_out, done_out;

  modport master (
    output point_ax, point_ay, vec_ab_x, vec_ab_y, vec_ac_x, vec_ac_y,
    output tri_valid_in, pix_ready_in,
    input  tri_ready_out, pix_x_out, pix_y_out, pix_valid_out, busy_out, done_out
  );

  modport slave (
    input  point_ax, point_ay, vec_ab_x, vec_ab_y, vec_ac_x, vec_ac_y,
    input  tri_valid_in, pix_ready_in,
    output tri_ready_out, pix_x_out, pix_y_out, pix_valid_out, busy_out, done_out
  );
endinterface

// File: rtl/tri_raster_edge_fn.sv
// Combinational signed 2-D cross product u.x*v.y - u.y*v.x, widened to OUT_W before multiplying.
module edge_fn #(
  parameter int IN_W  = 9,
  parameter int OUT_W = 18
) (
  input  logic signed [IN_W-1:0]  i_ux,
  input  logic signed [IN_W-1:0]  i_uy,
  input  logic signed [IN_W-1:0]  i_vx,
  input  logic signed [IN_W-1:0]  i_vy,
  output logic signed [OUT_W-1:0] o_cross
);
  function automatic logic signed [OUT_W-1:0] sext(input logic signed [IN_W-1:0] v);
    return {{(OUT_W-IN_W){v[IN_W-1]}}, v};
  endfunction

  assign o_cross = sext(i_ux) * sext(i_vy) - sext(i_uy) * sext(i_vx);
endmodule

// File: rtl/tri_raster.sv
// Triangle rasterizer: scans the clipped bounding box one candidate per cycle, streams covered pixels.
// Optional macro TRI_RASTER_BACKFACE_CULL_EN: negative-area triangles produce no pixels.
module tri_raster
  import fp3d_pkg::*;
#(
  parameter int MAX_BIT_WIDTH = COORD_W
) (
  input  logic        clk_in,
  input  logic        rst_in,
  tri_raster_if.slave bus
);
  localparam int W  = MAX_BIT_WIDTH;
  localparam int SW = W + 3;
  localparam int EW = 2 * W + 6;
  localparam logic signed [SW-1:0] MAXC = SW'((1 << W) - 1);

  function automatic logic signed [SW-1:0] sx_coord(input logic [W-1:0] c);
    return $signed({3'b000, c});
  endfunction

  function automatic logic signed [SW-1:0] sx_vec(input logic signed [W:0] v);
    return {{2{v[W]}}, v};
  endfunction

  function automatic logic signed [SW-1:0] min3(input logic signed [SW-1:0] a, b, c);
    logic signed [SW-1:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic logic signed [SW-1:0] max3(input logic signed [SW-1:0] a, b, c);
    logic signed [SW-1:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic logic [W-1:0] clip_lo(input logic signed [SW-1:0] v);
    return v[SW-1] ? '0 : v[W-1:0];
  endfunction

  function automatic logic [W-1:0] clip_hi(input logic signed [SW-1:0] v);
    return (v > MAXC) ? MAXC[W-1:0] : v[W-1:0];
  endfunction

  // Edges are inclusive; for clockwise triangles the sign of every term flips.
  function automatic logic edge_ok(input logic signed [EW-1:0] e, input logic neg);
    return neg ? (e[EW-1] || (e == '0)) : !e[EW-1];
  endfunction

  raster_state_t     r_state;
  logic [W-1:0]      r_ax, r_ay, r_px, r_py, r_xmin, r_xmax, r_ymax, r_pix_x, r_pix_y;
  logic signed [W:0] r_abx, r_aby, r_acx, r_acy;
  logic              r_valid, r_done;

  logic signed [SW-1:0] w_ax, w_ay, w_abx, w_aby, w_acx, w_acy, w_bx, w_by, w_cx, w_cy;
  logic signed [SW-1:0] w_px, w_py, w_dx, w_dy, w_eux, w_euy, w_qx, w_qy;
  logic signed [SW-1:0] w_lox, w_hix, w_loy, w_hiy;
  logic signed [EW-1:0] w_area, w_e1, w_e2, w_e3;
  logic                 w_degen, w_empty, w_inside, w_adv, w_last;

  assign w_ax  = sx_coord(r_ax);
  assign w_ay  = sx_coord(r_ay);
  assign w_abx = sx_vec(r_abx);
  assign w_aby = sx_vec(r_aby);
  assign w_acx = sx_vec(r_acx);
  assign w_acy = sx_vec(r_acy);
  assign w_bx  = w_ax + w_abx;
  assign w_by  = w_ay + w_aby;
  assign w_cx  = w_ax + w_acx;
  assign w_cy  = w_ay + w_acy;
  assign w_px  = sx_coord(r_px);
  assign w_py  = sx_coord(r_py);
  assign w_dx  = w_px - w_ax;
  assign w_dy  = w_py - w_ay;
  assign w_eux = w_acx - w_abx;
  assign w_euy = w_acy - w_aby;
  assign w_qx  = w_px - w_bx;
  assign w_qy  = w_py - w_by;

  assign w_lox = min3(w_ax, w_bx, w_cx);
  assign w_hix = max3(w_ax, w_bx, w_cx);
  assign w_loy = min3(w_ay, w_by, w_cy);
  assign w_hiy = max3(w_ay, w_by, w_cy);
  assign w_empty = w_hix[SW-1] || w_hiy[SW-1] || (w_lox > MAXC) || (w_loy > MAXC);

  edge_fn #(.IN_W(SW), .OUT_W(EW)) u_area (
    .i_ux(w_abx), .i_uy(w_aby), .i_vx(w_acx), .i_vy(w_acy), .o_cross(w_area));
  edge_fn #(.IN_W(SW), .OUT_W(EW)) u_e1 (
    .i_ux(w_abx), .i_uy(w_aby), .i_vx(w_dx), .i_vy(w_dy), .o_cross(w_e1));
  edge_fn #(.IN_W(SW), .OUT_W(EW)) u_e2 (
    .i_ux(w_dx), .i_uy(w_dy), .i_vx(w_acx), .i_vy(w_acy), .o_cross(w_e2));
  edge_fn #(.IN_W(SW), .OUT_W(EW)) u_e3 (
    .i_ux(w_eux), .i_uy(w_euy), .i_vx(w_qx), .i_vy(w_qy), .o_cross(w_e3));

`ifdef TRI_RASTER_BACKFACE_CULL_EN
  assign w_degen = (w_area == '0) || w_area[EW-1];
`else
  assign w_degen = (w_area == '0);
`endif

  assign w_inside = edge_ok(w_e1, w_area[EW-1]) && edge_ok(w_e2, w_area[EW-1]) &&
                    edge_ok(w_e3, w_area[EW-1]);
  assign w_adv  = !r_valid || bus.pix_ready_in;
  assign w_last = (r_px == r_xmax) && (r_py == r_ymax);

  // Control: FSM, output valid/pixel and done pulse
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_pix_x <= '0;
      r_pix_y <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE:  if (bus.tri_valid_in) r_state <= SETUP;
        SETUP: r_state <= (w_degen || w_empty) ? DRAIN : SCAN;
        SCAN: begin
          if (w_adv) begin
            r_pix_x <= r_px;
            r_pix_y <= r_py;
            r_valid <= w_inside;
            if (w_last) r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_adv) begin
            r_valid <= 1'b0;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Datapath: captured triangle, clipped box and scan position
  always_ff @(posedge clk_in) begin
    if (r_state == IDLE && bus.tri_valid_in) begin
      r_ax  <= bus.point_ax;
      r_ay  <= bus.point_ay;
      r_abx <= bus.vec_ab_x;
      r_aby <= bus.vec_ab_y;
      r_acx <= bus.vec_ac_x;
      r_acy <= bus.vec_ac_y;
    end
    if (r_state == SETUP) begin
      r_xmin <= clip_lo(w_lox);
      r_xmax <= clip_hi(w_hix);
      r_ymax <= clip_hi(w_hiy);
      r_px   <= clip_lo(w_lox);
      r_py   <= clip_lo(w_loy);
    end else if (r_state == SCAN && w_adv) begin
      if (r_px == r_xmax) begin
        r_px <= r_xmin;
        r_py <= r_py + 1'b1;
      end else begin
        r_px <= r_px + 1'b1;
      end
    end
  end

  assign bus.tri_ready_out = (r_state == IDLE);
  assign bus.busy_out      = (r_state != IDLE);
  assign bus.pix_valid_out = r_valid;
  assign bus.pix_x_out     = r_pix_x;
  assign bus.pix_y_out     = r_pix_y;
  assign bus.done_out      = r_done;
endmodule
